// File: rtl/branch_resolution_if.sv
// Execute-stage branch resolution bundle: decode/flag inputs toward the
// resolver and decision/statistics outputs back to the pipeline.
interface branch_resolution_if #(
  parameter int CNT_WIDTH = 16
);
  logic [2:0]           funct3;
  logic [1:0]           BranchOp;
  logic                 N;
  logic                 Z;
  logic                 C;
  logic                 V;
  logic                 PCSrc;
  logic                 BranchIllegal;
  logic                 PCSrcQ;
  logic [CNT_WIDTH-1:0] BranchCount;
  logic [CNT_WIDTH-1:0] TakenCount;

  modport master (
    output funct3, BranchOp, N, Z, C, V,
    input  PCSrc, BranchIllegal, PCSrcQ, BranchCount, TakenCount
  );

  modport slave (
    input  funct3, BranchOp, N, Z, C, V,
    output PCSrc, BranchIllegal, PCSrcQ, BranchCount, TakenCount
  );
endinterface

// File: rtl/branch_resolution.sv
// Combinational taken/not-taken decision for Execute, plus a registered copy
// of the decision and wrap-around conditional-branch statistics.
module branch_resolution #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  branch_resolution_if.slave   br
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_COND = 2'b10;

  logic                 w_pcsrc;
  logic                 w_illegal;
  logic                 w_count_branch;
  logic                 r_pcsrc_q;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_taken_cnt;

  // funct3 and flags are only looked at under OP_COND, so unknowns on them
  // cannot leak into the decision for jumps or non-branches.
  always_comb begin
    w_pcsrc   = 1'b0;
    w_illegal = 1'b0;
    case (br.BranchOp)
      OP_NONE: w_pcsrc = 1'b0;
      OP_JUMP: w_pcsrc = 1'b1;
      OP_COND: begin
        case (br.funct3)
          3'b000:  w_pcsrc = br.Z;
          3'b001:  w_pcsrc = ~br.Z;
          3'b100:  w_pcsrc = br.N ^ br.V;
          3'b101:  w_pcsrc = ~(br.N ^ br.V);
          3'b110:  w_pcsrc = ~br.C;
          3'b111:  w_pcsrc = br.C;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_count_branch = (br.BranchOp == OP_COND) && !w_illegal;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pcsrc_q    <= 1'b0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_pcsrc_q <= w_pcsrc;
      if (w_count_branch) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
        if (w_pcsrc)
          r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

  assign br.PCSrc         = w_pcsrc;
  assign br.BranchIllegal = w_illegal;
  assign br.PCSrcQ        = r_pcsrc_q;
  assign br.BranchCount   = r_branch_cnt;
  assign br.TakenCount    = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolution.sv
// Randomized self-checking bench for branch_resolution; conditional branches
// are mostly generated from real operand compares to derive expected outcomes.
module tb_branch_resolution;

  localparam int CW = 4;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   m_branch;
  int   m_taken;
  int   m_q;

  branch_resolution_if #(.CNT_WIDTH(CW)) bif ();

  branch_resolution #(.CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .br      (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decision rule for a legal conditional branch, stated in terms of flags.
  function automatic bit flag_rule(input logic [2:0] f3, input bit n, input bit z,
                                   input bit c, input bit v);
    bit signed_lt;
    signed_lt = (n != v);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return signed_lt;
      3'b101:  return !signed_lt;
      3'b110:  return !c;
      default: return c;
    endcase
  endfunction

  // One cycle: drive, check combinational outputs, clock, check registers.
  task automatic step(input string tag, input logic [1:0] bop, input logic [2:0] f3,
                      input bit n, input bit z, input bit c, input bit v,
                      input bit rst_n, input bit exp_pc, input bit exp_ill);
    bif.BranchOp = bop;
    bif.funct3   = f3;
    bif.N = n; bif.Z = z; bif.C = c; bif.V = v;
    reset_n = rst_n;
    #1;
    check_eq({tag, ".pcsrc"}, bif.PCSrc, exp_pc);
    check_eq({tag, ".illegal"}, bif.BranchIllegal, exp_ill);
    @(posedge clk);
    if (!rst_n) begin
      m_q = 0; m_branch = 0; m_taken = 0;
    end else begin
      m_q = exp_pc;
      if (bop == 2'b10 && !exp_ill) begin
        m_branch = (m_branch + 1) % (1 << CW);
        if (exp_pc) m_taken = (m_taken + 1) % (1 << CW);
      end
    end
    #1;
    check_eq({tag, ".q"}, bif.PCSrcQ, m_q);
    check_eq({tag, ".bcnt"}, bif.BranchCount, m_branch);
    check_eq({tag, ".tcnt"}, bif.TakenCount, m_taken);
    $display("txn %-10s op=%b f3=%b nzcv=%b%b%b%b rst_n=%b pc=%b q=%b bc=%0d tc=%0d",
             tag, bop, f3, n, z, c, v, rst_n, bif.PCSrc, bif.PCSrcQ,
             bif.BranchCount, bif.TakenCount);
  endtask

  // Random compare of two bytes: flags from the subtraction, expected
  // outcome from the operand relation itself.
  task automatic operand_branch(input string tag, input bit rst_n);
    logic [7:0] a, b, d;
    logic [2:0] f3;
    bit n, z, c, v, exp;
    int sel;
    a = 8'($urandom); b = 8'($urandom);
    if ($urandom_range(0, 3) == 0) b = a;
    d = a - b;
    z = (a == b);
    c = (a >= b);
    n = d[7];
    v = (a[7] != b[7]) && (d[7] != a[7]);
    sel = $urandom_range(0, 5);
    case (sel)
      0: begin f3 = 3'b000; exp = (a == b); end
      1: begin f3 = 3'b001; exp = (a != b); end
      2: begin f3 = 3'b100; exp = ($signed(a) <  $signed(b)); end
      3: begin f3 = 3'b101; exp = ($signed(a) >= $signed(b)); end
      4: begin f3 = 3'b110; exp = (a < b); end
      default: begin f3 = 3'b111; exp = (a >= b); end
    endcase
    step(tag, 2'b10, f3, n, z, c, v, rst_n, exp, 1'b0);
  endtask

  initial begin
    logic [2:0] legal_f3 [6];
    logic [3:0] fl;
    n_checks = 0; n_errors = 0;
    m_branch = 0; m_taken = 0; m_q = 0;
    legal_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    // Reset held two cycles while a taken jump is presented.
    step("reset0", 2'b01, 3'b000, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step("reset1", 2'b01, 3'b000, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Directed registered-path sequence.
    step("beq_t", 2'b10, 3'b000, 0, 1, 1, 0, 1'b1, 1'b1, 1'b0);
    check_eq("dir.bc1", bif.BranchCount, 1);
    check_eq("dir.tc1", bif.TakenCount, 1);
    step("bne_nt", 2'b10, 3'b001, 0, 1, 1, 0, 1'b1, 1'b0, 1'b0);
    check_eq("dir.bc2", bif.BranchCount, 2);
    check_eq("dir.tc2", bif.TakenCount, 1);
    check_eq("dir.q2", bif.PCSrcQ, 0);

    // Non-branch and jump with random flags.
    for (int i = 0; i < 8; i++) begin
      fl = 4'($urandom);
      step("nonbr", 2'b00, 3'($urandom), fl[3], fl[2], fl[1], fl[0], 1'b1, 1'b0, 1'b0);
      fl = 4'($urandom);
      step("jump", 2'b01, 3'($urandom), fl[3], fl[2], fl[1], fl[0], 1'b1, 1'b1, 1'b0);
    end

    // Exhaustive flags over the legal conditions.
    for (int k = 0; k < 6; k++) begin
      for (int f = 0; f < 16; f++) begin
        fl = 4'(f);
        step("exh", 2'b10, legal_f3[k], fl[3], fl[2], fl[1], fl[0], 1'b1,
             flag_rule(legal_f3[k], fl[3], fl[2], fl[1], fl[0]), 1'b0);
      end
    end
    step("blt_ex", 2'b10, 3'b100, 1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    step("bge_ex", 2'b10, 3'b101, 1, 0, 0, 1, 1'b1, 1'b1, 1'b0);
    step("bltu_ex", 2'b10, 3'b110, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0);

    // Illegal encodings.
    for (int i = 0; i < 4; i++) begin
      fl = 4'($urandom);
      step("ill_010", 2'b10, 3'b010, fl[3], fl[2], fl[1], fl[0], 1'b1, 1'b0, 1'b1);
      step("ill_011", 2'b10, 3'b011, fl[3], fl[2], fl[1], fl[0], 1'b1, 1'b0, 1'b1);
      step("ill_op11", 2'b11, 3'($urandom), fl[3], fl[2], fl[1], fl[0], 1'b1, 1'b0, 1'b1);
    end

    // Wrap-around: 17 taken beq from a cleared state.
    step("wrap_rst", 2'b00, 3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++)
      step("wrap", 2'b10, 3'b000, 0, 1, 1, 0, 1'b1, 1'b1, 1'b0);
    check_eq("wrap.bc", bif.BranchCount, 1);
    check_eq("wrap.tc", bif.TakenCount, 1);

    // Reset coinciding with a taken branch.
    step("pre_rst", 2'b10, 3'b111, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
    step("rst_tkn", 2'b10, 3'b000, 0, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    check_eq("rstmid.bc", bif.BranchCount, 0);
    check_eq("rstmid.tc", bif.TakenCount, 0);

    // Mixed random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      bit rn;
      int kind;
      rn = ($urandom_range(0, 24) != 0);
      kind = $urandom_range(0, 9);
      fl = 4'($urandom);
      if (kind < 6)
        operand_branch("rnd_cond", rn);
      else if (kind == 6)
        step("rnd_none", 2'b00, 3'($urandom), fl[3], fl[2], fl[1], fl[0], rn, 1'b0, 1'b0);
      else if (kind == 7)
        step("rnd_jump", 2'b01, 3'($urandom), fl[3], fl[2], fl[1], fl[0], rn, 1'b1, 1'b0);
      else if (kind == 8)
        step("rnd_ill", 2'b11, 3'($urandom), fl[3], fl[2], fl[1], fl[0], rn, 1'b0, 1'b1);
      else
        step("rnd_f3ill", 2'b10, {2'b01, 1'($urandom)}, fl[3], fl[2], fl[1], fl[0], rn,
             1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolution.md
# branch_resolution

Resolves the taken/not-taken decision for the pipeline's Execute stage. It combines the decoded branch class (BranchOp) and the instruction's funct3 with the ALU condition flags N, Z, C and V to produce PCSrc, which selects the redirect target for the next PC. A registered copy of the decision and wrap-around branch statistics counters are also provided for hazard and performance logic.

## Interface
Parameters:
- CNT_WIDTH, default 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge. One clock only.
- reset_n  input  1  reset, synchronous, active-low.
- funct3  input  3  branch condition code from the instruction.
- BranchOp  input  2  00 = non-branch, 01 = unconditional jump, 10 = conditional branch, 11 = reserved.
- N  input  1  ALU negative flag.
- Z  input  1  ALU zero flag.
- C  input  1  ALU carry flag. C = 1 means no borrow on the compare subtraction (unsigned rs1 >= rs2).
- V  input  1  ALU signed overflow flag.
- PCSrc  output  1  combinational; 1 = take the branch or jump target.
- BranchIllegal  output  1  combinational; flags a reserved BranchOp or an undefined branch funct3.
- PCSrcQ  output  1  PCSrc registered by one cycle.
- BranchCount  output  CNT_WIDTH  number of legal conditional branches resolved.
- TakenCount  output  CNT_WIDTH  number of those conditional branches that were taken.

## Operation
PCSrc is purely combinational and uses no state.
- BranchOp 00: PCSrc = 0.
- BranchOp 01: PCSrc = 1, for any flag values.
- BranchOp 11: PCSrc = 0 and BranchIllegal = 1.
- BranchOp 10: PCSrc is selected by funct3 as follows.
  - 000 (beq): PCSrc = Z.
  - 001 (bne): PCSrc = ~Z.
  - 100 (blt): PCSrc = N ^ V.
  - 101 (bge): PCSrc = ~(N ^ V).
  - 110 (bltu): PCSrc = ~C.
  - 111 (bgeu): PCSrc = C.
  - 010 or 011: PCSrc = 0 and BranchIllegal = 1.
- In every other case BranchIllegal = 0.
- funct3 and the flags are ignored unless BranchOp = 10.
- PCSrc never depends on reset_n.
- Any input carrying X or Z must not cause an X on PCSrc for the cases where that input is ignored.

Registered state, updated on the rising edge of clk:
- If reset_n = 0, then PCSrcQ, BranchCount and TakenCount are all cleared to 0.
- Otherwise PCSrcQ takes the current PCSrc.
- Otherwise BranchCount increments by 1 when BranchOp = 10 and BranchIllegal = 0.
- TakenCount increments by 1 when that same condition holds and PCSrc = 1.
- Both counters wrap modulo 2^CNT_WIDTH; all-ones + 1 gives 0, with no saturation and no sticky flag.
- Jumps, non-branch cycles and illegal encodings never change either counter.

## Timing
- PCSrc and BranchIllegal have zero-cycle latency: they settle within the same cycle as the inputs and must meet Execute-to-PC-mux timing.
- PCSrcQ, BranchCount and TakenCount reflect the inputs sampled at the previous rising edge (1-cycle latency).
- Reset values are: PCSrcQ = 0, BranchCount = 0, TakenCount = 0. PCSrc and BranchIllegal follow the inputs even while reset_n = 0.
- When reset_n = 0 coincides with a qualifying branch, reset wins and the counters read 0 on the next cycle.
- Deasserting reset mid-stream means counting resumes from the first edge sampled with reset_n = 1.
- There is no handshake; one decision is made per cycle and the block cannot stall.

## Test plan
- Non-branch and jump: BranchOp = 00 with any flags -> PCSrc = 0. BranchOp = 01 -> PCSrc = 1. Neither changes the counters.
- Exhaustive conditional check: BranchOp = 10, each of the six legal funct3 values against all 16 NZCV combinations -> PCSrc matches the Operation list. For example, funct3 = 100 with N = 1, V = 0 -> 1; funct3 = 101 with N = 1, V = 1 -> 1; funct3 = 110 with C = 1 -> 0.
- Illegal encodings: BranchOp = 10 with funct3 = 010 or 011, and BranchOp = 11 -> PCSrc = 0, BranchIllegal = 1, counters unchanged.
- Registered path: hold reset_n = 0 for 2 cycles -> all registered outputs are 0. Release, then apply beq with Z = 1 for 1 cycle -> next cycle PCSrcQ = 1, BranchCount = 1, TakenCount = 1. Then apply bne with Z = 1 -> BranchCount = 2, TakenCount = 1, PCSrcQ = 0.
- Wrap-around: with CNT_WIDTH = 4, issue 17 taken beq -> BranchCount = 1 and TakenCount = 1.
- Reset mid-operation: assert reset_n = 0 in the same cycle as a taken branch -> counters read 0 on the next cycle, and PCSrc still equals 1 during that cycle.
